// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for nbit_alu_seq and alu_mul_seq.
//   - OP_* : 4-bit opcodes on the sel input
//   - state_t / ST_* : controller state encoding (IDLE, MUL, HOLD)
//   - FLG_* : bit positions inside the 4-bit flags vector {v, n, c, z}
// Build option: ALU_MUL_EN enables the multi-cycle MULLO/MULHI path.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_INC   = 4'h2;
  localparam logic [3:0] OP_DEC   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_NOT   = 4'h7;
  localparam logic [3:0] OP_NAND  = 4'h8;
  localparam logic [3:0] OP_NOR   = 4'h9;
  localparam logic [3:0] OP_XNOR  = 4'hA;
  localparam logic [3:0] OP_SHL   = 4'hB;
  localparam logic [3:0] OP_SHR   = 4'hC;
  localparam logic [3:0] OP_CMP   = 4'hD;
  localparam logic [3:0] OP_MULLO = 4'hE;
  localparam logic [3:0] OP_MULHI = 4'hF;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: WIDTH-step shift-add multiplier (one partial-product add per clock).
// Only compiled when ALU_MUL_EN is defined.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : load operands and clear the partial product
//   a, b        : multiplicand / multiplier (WIDTH bits)
//   busy        : steps remaining
//   done        : the step performed at the coming edge is the last one
//   product     : 2*WIDTH-bit product; holds the final value while done=1
`ifdef ALU_MUL_EN
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;

  // Right-shifting accumulator: add the multiplicand into the upper half when
  // the current multiplier bit is set, then shift the whole thing right by one.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
    acc_next = {sum, acc[WIDTH-1:1]};
  end

  // Exposing the next accumulator value lets the controller capture the result
  // on the same edge as the final step.
  assign done    = busy && (cnt == CNT_W'(1));
  assign product = acc_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CNT_W'(WIDTH);
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) busy <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/nbit_alu_seq.sv
// nbit_alu_seq: WIDTH-bit, 16-opcode ALU with registered result and
// valid/ready handshakes on both sides.
// Build option: ALU_MUL_EN adds the multi-cycle MULLO/MULHI multiplier
// (alu_mul_seq); without it those opcodes complete in one cycle as illegal.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   i1, i2, sel         : operands and opcode, sampled only on acceptance
//   in_valid, in_ready  : issue-side handshake
//   o1                  : result, bit WIDTH is carry/borrow/shifted-out bit
//   flags               : {v, n, c, z}
//   illegal             : accepted opcode is not compiled in
//   out_valid, out_ready: writeback-side handshake
module nbit_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [3:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   o1,
  output logic [3:0]       flags,
  output logic             illegal,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t         state;
  logic [WIDTH:0] res_p1;
  logic [3:0]     flg_p1;
  logic           ill_p1;
  logic           vld_p1;
  logic           accept;
  logic [WIDTH:0] a_x;
  logic [WIDTH:0] b_x;
  logic [WIDTH:0] alu_res;
  logic           alu_v;
  logic           alu_ill;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] r);
    return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] r);
    return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic [3:0] mk_flags(input logic [WIDTH:0] r, input logic v);
    logic [3:0] f;
    f        = '0;
    f[FLG_Z] = (r[WIDTH-1:0] == '0);
    f[FLG_C] = r[WIDTH];
    f[FLG_N] = r[WIDTH-1];
    f[FLG_V] = v;
    return f;
  endfunction

  assign a_x = {1'b0, i1};
  assign b_x = {1'b0, i2};

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (sel)
      OP_ADD: begin
        alu_res = a_x + b_x;
        alu_v   = add_ovf(i1, i2, alu_res[WIDTH-1:0]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = a_x - b_x;
        alu_v   = sub_ovf(i1, i2, alu_res[WIDTH-1:0]);
      end
      OP_INC: begin
        alu_res = a_x + {1'b0, ONE};
        alu_v   = add_ovf(i1, ONE, alu_res[WIDTH-1:0]);
      end
      OP_DEC: begin
        alu_res = a_x - {1'b0, ONE};
        alu_v   = sub_ovf(i1, ONE, alu_res[WIDTH-1:0]);
      end
      OP_AND:  alu_res = {1'b0, i1 & i2};
      OP_OR:   alu_res = {1'b0, i1 | i2};
      OP_XOR:  alu_res = {1'b0, i1 ^ i2};
      OP_NOT:  alu_res = {1'b0, ~i1};
      OP_NAND: alu_res = {1'b0, ~(i1 & i2)};
      OP_NOR:  alu_res = {1'b0, ~(i1 | i2)};
      OP_XNOR: alu_res = {1'b0, ~(i1 ^ i2)};
      OP_SHL:  alu_res = {i1, 1'b0};
      OP_SHR:  alu_res = {i1[0], 1'b0, i1[WIDTH-1:1]};
      // MULLO/MULHI land here; they only count as illegal when the
      // multiplier is not built (the MUL path ignores alu_ill).
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  logic               is_mul;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic               hi_sel;
  logic [WIDTH-1:0]   mul_half;

  assign is_mul    = (sel == OP_MULLO) || (sel == OP_MULHI);
  assign mul_start = accept && is_mul;
  assign mul_half  = hi_sel ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (i1),
    .b       (i2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign in_ready = rst_n && !mul_busy &&
                    ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));
`else
  assign in_ready = rst_n &&
                    ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));
`endif

  assign accept = in_valid && in_ready;

  // ---- stage p1: registered result, held until the consumer takes it ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      vld_p1 <= 1'b0;
      res_p1 <= '0;
      flg_p1 <= '0;
      ill_p1 <= 1'b0;
`ifdef ALU_MUL_EN
      hi_sel <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
`ifdef ALU_MUL_EN
            if (is_mul) begin
              state  <= ST_MUL;
              vld_p1 <= 1'b0;
              hi_sel <= (sel == OP_MULHI);
            end else
`endif
            begin
              state  <= ST_HOLD;
              vld_p1 <= 1'b1;
              res_p1 <= alu_res;
              flg_p1 <= alu_ill ? 4'b0000 : mk_flags(alu_res, alu_v);
              ill_p1 <= alu_ill;
            end
          end else if ((state == ST_HOLD) && out_ready) begin
            state  <= ST_IDLE;
            vld_p1 <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        ST_MUL: begin
          if (mul_done) begin
            state  <= ST_HOLD;
            vld_p1 <= 1'b1;
            res_p1 <= {1'b0, mul_half};
            flg_p1 <= mk_flags({1'b0, mul_half}, 1'b0);
            ill_p1 <= 1'b0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o1        = res_p1;
  assign flags     = flg_p1;
  assign illegal   = ill_p1;
  assign out_valid = vld_p1;

endmodule
